mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_ctrl_pkg.sv | 16 +
 rtl/access_timer.sv | 29 ++
 rtl/mem_access_ctrl.sv | 126 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory access controller.
// State encoding and default parameter values.
package mem_ctrl_pkg;

  localparam int DefWidth   = 8;
  localparam int DefLength  = 8;
  localparam int DefTimeout = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } ctrlState_t;

endpackage

// File: rtl/access_timer.sv
// WAIT-cycle counter for the memory access controller.
// expired flags the last WAIT cycle allowed before giving up.
module access_timer
  import mem_ctrl_pkg::*;
#(
  parameter int timeout = DefTimeout
) (
  input  logic clk,
  input  logic clr,
  input  logic start,
  input  logic tick,
  output logic expired
);

  logic [3:0] count;

  assign expired = (count == 4'(timeout - 1));

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      count <= '0;
    end else if (start) begin
      count <= '0;
    end else if (tick && !expired) begin
      count <= count + 4'd1;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store controller in front of the data RAM stage.
// Every output is a flop or a direct copy of the latched request.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int width   = DefWidth,
  parameter int length  = DefLength,
  parameter int timeout = DefTimeout
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              reqWrite,
  input  logic              reqIndirect,
  input  logic [length-1:0] reqAddr,
  input  logic [width-1:0]  reqData,
  output logic              respValid,
  output logic [width-1:0]  respData,
  output logic              respError,
  output logic              ramReadEnable,
  output logic              ramWriteEnable,
  output logic              ramIndirect,
  output logic [length-1:0] ramReadAddr,
  output logic [length-1:0] ramWriteAddr,
  output logic [width-1:0]  ramWriteData,
  input  logic              ramDataReady,
  input  logic [width-1:0]  ramReadData,
  output logic [7:0]        errCount
);

  ctrlState_t        state;
  logic              rqWrite;
  logic              rqInd;
  logic [length-1:0] rqAddr;
  logic [width-1:0]  rqData;
  logic              timerStart;
  logic              timerTick;
  logic              expired;

  assign timerStart   = (state == ISSUE);
  assign timerTick    = (state == WAIT);
  assign ramReadAddr  = rqAddr;
  assign ramWriteAddr = rqAddr;
  assign ramWriteData = rqData;
  assign ramIndirect  = rqInd;

  access_timer #(
    .timeout(timeout)
  ) uTimer (
    .clk    (clk),
    .clr    (clr),
    .start  (timerStart),
    .tick   (timerTick),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state          <= IDLE;
      reqReady       <= 1'b0;
      respValid      <= 1'b0;
      respData       <= '0;
      respError      <= 1'b0;
      errCount       <= '0;
      ramReadEnable  <= 1'b0;
      ramWriteEnable <= 1'b0;
      rqWrite        <= 1'b0;
      rqInd          <= 1'b0;
      rqAddr         <= '0;
      rqData         <= '0;
    end else begin
      reqReady       <= 1'b0;
      respValid      <= 1'b0;
      ramReadEnable  <= 1'b0;
      ramWriteEnable <= 1'b0;
      unique case (state)
        IDLE: begin
          if (reqValid && reqReady) begin
            rqWrite        <= reqWrite;
            rqInd          <= reqIndirect & ~reqWrite;
            rqAddr         <= reqAddr;
            rqData         <= reqData;
            ramWriteEnable <= reqWrite;
            ramReadEnable  <= ~reqWrite;
            state          <= ISSUE;
          end else begin
            reqReady <= 1'b1;
          end
        end
        ISSUE: begin
          if (rqWrite) begin
            state     <= RESP;
            respValid <= 1'b1;
            respData  <= '0;
            respError <= 1'b0;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          // data arriving on the final allowed cycle still wins
          if (ramDataReady) begin
            state     <= RESP;
            respValid <= 1'b1;
            respData  <= ramReadData;
            respError <= 1'b0;
          end else if (expired) begin
            state     <= RESP;
            respValid <= 1'b1;
            respData  <= '0;
            respError <= 1'b1;
            if (errCount != 8'hFF) begin
              errCount <= errCount + 8'd1;
            end
          end
        end
        RESP: begin
          state    <= IDLE;
          reqReady <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a transaction-level model.
// The RAM stage is emulated from the model's own schedule.
module tb_mem_access_ctrl;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       clr;
  logic       reqValid;
  logic       reqReady;
  logic       reqWrite;
  logic       reqIndirect;
  logic [7:0] reqAddr;
  logic [7:0] reqData;
  logic       respValid;
  logic [7:0] respData;
  logic       respError;
  logic       ramReadEnable;
  logic       ramWriteEnable;
  logic       ramIndirect;
  logic [7:0] ramReadAddr;
  logic [7:0] ramWriteAddr;
  logic [7:0] ramWriteData;
  logic       ramDataReady = 1'b0;
  logic [7:0] ramReadData = 8'h00;
  logic [7:0] errCount;

  mem_access_ctrl #(
    .width  (8),
    .length (8),
    .timeout(T)
  ) dut (
    .clk           (clk),
    .clr           (clr),
    .reqValid      (reqValid),
    .reqReady      (reqReady),
    .reqWrite      (reqWrite),
    .reqIndirect   (reqIndirect),
    .reqAddr       (reqAddr),
    .reqData       (reqData),
    .respValid     (respValid),
    .respData      (respData),
    .respError     (respError),
    .ramReadEnable (ramReadEnable),
    .ramWriteEnable(ramWriteEnable),
    .ramIndirect   (ramIndirect),
    .ramReadAddr   (ramReadAddr),
    .ramWriteAddr  (ramWriteAddr),
    .ramWriteData  (ramWriteData),
    .ramDataReady  (ramDataReady),
    .ramReadData   (ramReadData),
    .errCount      (errCount)
  );

  always #5 clk = ~clk;

  int nVec = 0;
  int nBad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // model state: one transaction, described by its accept edge and
  // the edge on which its response appears
  logic [7:0] refMem [256];
  int         cyc = 0;
  int         accCnt = 0;
  int         rdyDelay = 0;
  bit         mBusy = 0;
  bit         mFresh = 1;
  int         tA = 0;
  int         rspAt = 0;
  int         tD = 0;
  bit         tW = 0;
  bit         tInd = 0;
  bit         tErr = 0;
  logic [7:0] tAddr = 0;
  logic [7:0] tData = 0;
  logic [7:0] tRd = 0;
  logic [7:0] lastData = 0;
  bit         lastErr = 0;
  int         errCnt = 0;

  function automatic bit inTime(input int d);
    return d >= 0 && d < T;
  endfunction

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      mBusy    <= 0;
      mFresh   <= 1;
      errCnt   <= 0;
      lastData <= 0;
      lastErr  <= 0;
    end else begin
      cyc    <= cyc + 1;
      mFresh <= 0;
      if (mBusy && cyc + 1 == rspAt) begin
        lastData <= tErr ? 8'h00 : tRd;
        lastErr  <= tErr;
        if (tErr && errCnt < 255) errCnt <= errCnt + 1;
      end
      if (mBusy && cyc + 1 == rspAt + 1) mBusy <= 0;
      if (!mBusy && !mFresh && reqValid) begin
        mBusy  <= 1;
        accCnt <= accCnt + 1;
        tA     <= cyc + 1;
        tW     <= reqWrite;
        tInd   <= reqIndirect && !reqWrite;
        tAddr  <= reqAddr;
        tData  <= reqData;
        tD     <= rdyDelay;
        tErr   <= !reqWrite && !inTime(rdyDelay);
        if (reqWrite) begin
          tRd   <= 8'h00;
          rspAt <= cyc + 2;
          refMem[reqAddr] <= reqData;
        end else begin
          tRd   <= reqIndirect ? refMem[refMem[reqAddr]]
                               : refMem[reqAddr];
          rspAt <= cyc + 1 + (inTime(rdyDelay) ? 2 + rdyDelay : 1 + T);
        end
      end
    end
  end

  int         lastRespCyc = 0;
  int         weCnt = 0;
  int         reCnt = 0;
  int         rvCnt = 0;
  bit         lastInd = 0;

  // compare + RAM-stage driver, once per cycle on the falling edge
  always @(negedge clk) begin
    if (!clr) begin
      chk("rst_ready", reqReady, 0);
      chk("rst_rv", respValid, 0);
      chk("rst_data", respData, 0);
      chk("rst_err", respError, 0);
      chk("rst_errcnt", errCount, 0);
      chk("rst_ram", {ramReadEnable, ramWriteEnable, ramIndirect}, 0);
      chk("rst_addr", {ramReadAddr, ramWriteAddr, ramWriteData}, 0);
    end else begin
      chk("ready", reqReady, !mBusy && !mFresh);
      chk("we", ramWriteEnable, mBusy && tW && cyc == tA);
      chk("re", ramReadEnable, mBusy && !tW && cyc == tA);
      chk("rv", respValid, mBusy && cyc == rspAt);
      chk("respData", respData, lastData);
      chk("respError", respError, lastErr);
      chk("errCount", errCount, errCnt);
      if (mBusy && cyc == tA) begin
        chk("rdAddr", ramReadAddr, tAddr);
        chk("wrAddr", ramWriteAddr, tAddr);
        chk("ind", ramIndirect, tInd);
        if (tW) chk("wrData", ramWriteData, tData);
      end
    end
    if (respValid) begin
      lastRespCyc <= cyc;
      rvCnt <= rvCnt + 1;
    end
    if (ramWriteEnable) weCnt <= weCnt + 1;
    if (ramReadEnable) begin
      reCnt   <= reCnt + 1;
      lastInd <= ramIndirect;
    end
    ramReadData <= 8'($urandom);
    if (mBusy && !tW) begin
      // a strobe during ISSUE must be ignored
      ramDataReady <= 1'b0;
      if (cyc == tA) begin
        ramDataReady <= 1'b1;
      end else if (tD >= 0 && cyc == tA + 1 + tD) begin
        ramDataReady <= 1'b1;
        ramReadData  <= tRd;
      end
    end else begin
      ramDataReady <= 1'($urandom_range(0, 1));
    end
  end

  task automatic doReq(input bit w, input bit ind, input logic [7:0] a,
                       input logic [7:0] d, input int dly, input bit hold);
    int n0;
    n0 = accCnt;
    @(negedge clk);
    reqValid    = 1'b1;
    reqWrite    = w;
    reqIndirect = ind;
    reqAddr     = a;
    reqData     = d;
    rdyDelay    = dly;
    for (int i = 0; i < 40 && accCnt == n0; i++) @(negedge clk);
    if (accCnt == n0) begin
      nVec++;
      nBad++;
      $display("FAIL accept_timeout: got none want accept");
    end
    if (!hold) reqValid = 1'b0;
  endtask

  task automatic waitIdle();
    int i;
    i = 0;
    while (mBusy && i < 40) begin
      @(negedge clk);
      i++;
    end
    if (mBusy) begin
      nVec++;
      nBad++;
      $display("FAIL idle_timeout: got busy want idle");
    end
    @(negedge clk);
  endtask

  int w0, r0, a1, v0;

  initial begin
    for (int i = 0; i < 256; i++) refMem[i] = 8'h00;
    clr         = 1'b0;
    reqValid    = 1'b0;
    reqWrite    = 1'b0;
    reqIndirect = 1'b0;
    reqAddr     = 8'h00;
    reqData     = 8'h00;
    repeat (2) @(negedge clk);
    #1 chk("por_ready", reqReady, 0);
    chk("por_errcnt", errCount, 0);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    chk("first_ready", reqReady, 1);

    // plain store
    w0 = weCnt; r0 = reCnt;
    doReq(1, 0, 8'h10, 8'hA5, 0, 0);
    waitIdle();
    chk("st_lat", lastRespCyc + 1 - tA, 2);
    chk("st_we_pulses", weCnt - w0, 1);
    chk("st_re_pulses", reCnt - r0, 0);
    chk("st_resp", {respError, respData}, 9'h000);

    // load back, immediate ready
    r0 = reCnt;
    doReq(0, 0, 8'h10, 8'h00, 0, 0);
    waitIdle();
    chk("ld_lat", lastRespCyc + 1 - tA, 3);
    chk("ld_data", respData, 8'hA5);
    chk("ld_re_pulses", reCnt - r0, 1);
    chk("ld_ind", lastInd, 0);

    // indirect through RAM[0x20] -> 0x30
    doReq(1, 1, 8'h20, 8'h30, 0, 0);
    waitIdle();
    doReq(1, 0, 8'h30, 8'h7E, 0, 0);
    waitIdle();
    doReq(0, 1, 8'h20, 8'h00, 1, 0);
    waitIdle();
    chk("ind_flag", lastInd, 1);
    chk("ind_data", respData, 8'h7E);
    chk("ind_lat", lastRespCyc + 1 - tA, 4);

    // ready never arrives
    doReq(0, 0, 8'h10, 8'h00, -1, 0);
    waitIdle();
    chk("to_err", respError, 1);
    chk("to_data", respData, 8'h00);
    chk("to_errcnt", errCount, 1);
    chk("to_lat", lastRespCyc + 1 - tA, 2 + T);

    // ready on last allowed WAIT cycle, then one cycle too late
    doReq(0, 0, 8'h30, 8'h00, T - 1, 0);
    waitIdle();
    chk("last_err", respError, 0);
    chk("last_data", respData, 8'h7E);
    chk("last_errcnt", errCount, 1);
    doReq(0, 0, 8'h30, 8'h00, T, 0);
    waitIdle();
    chk("late_err", respError, 1);
    chk("late_errcnt", errCount, 2);

    // reqValid held across two requests
    w0 = weCnt; r0 = reCnt;
    doReq(1, 0, 8'h40, 8'h5C, 0, 1);
    a1 = tA;
    doReq(0, 0, 8'h40, 8'h00, 0, 0);
    chk("b2b_gap", tA - a1, 3);
    waitIdle();
    chk("b2b_data", respData, 8'h5C);
    chk("b2b_we", weCnt - w0, 1);
    chk("b2b_re", reCnt - r0, 1);

    // reset while waiting for data
    doReq(0, 0, 8'h10, 8'h00, -1, 0);
    @(negedge clk);
    v0 = rvCnt;
    #3 clr = 1'b0;
    #1 chk("mid_ready", reqReady, 0);
    chk("mid_resp", {respValid, respError, respData}, 10'h000);
    chk("mid_ram", {ramReadEnable, ramWriteEnable, ramIndirect}, 0);
    chk("mid_addr", {ramReadAddr, ramWriteAddr, ramWriteData}, 0);
    chk("mid_errcnt", errCount, 0);
    repeat (2) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    chk("rel_ready", reqReady, 1);
    repeat (2 * T) @(negedge clk);
    chk("no_resp", rvCnt - v0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule
